// File: rtl/dmem_access_unit.sv
// dmem_access_unit
// ----------------
// MEM-stage data-memory access unit. A MEM-stage load/store request is
// turned into a registered, word-aligned bus transaction (byte enables plus
// replicated store data). The pipeline is held with `stall` until the bus
// acknowledges. For loads the returned word, the address low bits and the
// load-extension opcode are registered for the WB-side load extender.
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   defined   : misaligned word/halfword requests raise exc_adel/exc_ades
//               combinationally and issue no bus transaction.
//   undefined : exc_adel/exc_ades tied low; misaligned requests proceed with
//               a word-aligned address and truncated halfword/byte offsets.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   mem_valid/we/size   MEM-stage request: valid, store flag, access size
//   mem_ld_op           load-extension code carried through to wb_op
//   mem_addr/wdata      byte address and raw store data
//   flush               kill the MEM-stage instruction
//   stall               freeze the upstream pipeline registers
//   bus_req/we/addr/be/wdata   registered bus transaction
//   bus_ack/rdata       slave completion and read word
//   wb_valid            one-cycle pulse: load data captured
//   wb_rdata/wb_a/wb_op captured read word, address low bits, load opcode
//   exc_adel/exc_ades   misaligned load/store (align-check build only)

module dmem_access_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic [2:0]  mem_ld_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        flush,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_rdata,
    output logic [1:0]  wb_a,
    output logic [2:0]  wb_op,
    output logic        exc_adel,
    output logic        exc_ades
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nxt;
    logic        accept;      // request latched this cycle
    logic        misaligned;
    logic        is_load;     // outstanding access is a load
    logic        kill;        // outstanding load was flushed
    logic [3:0]  be_c;
    logic [31:0] wdata_c;

    // Byte enables and lane-replicated store data; size 11 behaves as word.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = mem_wdata;
        case (mem_size)
            2'b01: begin
                be_c    = mem_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{mem_wdata[15:0]}};
            end
            2'b10: begin
                be_c    = 4'b0001 << mem_addr[1:0];
                wdata_c = {4{mem_wdata[7:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = mem_wdata;
            end
        endcase
    end

`ifdef DMEM_ALIGN_CHECK_EN
    always_comb begin
        case (mem_size)
            2'b01:   misaligned = mem_addr[0];
            2'b10:   misaligned = 1'b0;
            default: misaligned = (mem_addr[1:0] != 2'b00);
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        stall     = 1'b0;
        exc_adel  = 1'b0;
        exc_ades  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_valid && !flush) begin
                    if (misaligned) begin
                        exc_adel = !mem_we;
                        exc_ades = mem_we;
                    end else begin
                        accept    = 1'b1;
                        stall     = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = !bus_ack;
                if (bus_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Combinational outputs must read as idle while reset is held,
        // even though the request inputs may still be active.
        if (!reset_n) begin
            stall    = 1'b0;
            exc_adel = 1'b0;
            exc_ades = 1'b0;
        end
    end

    // Bus side: captured on accept, held stable through BUSY and afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_be    <= 4'b0000;
            bus_wdata <= 32'h0;
            is_load   <= 1'b0;
            kill      <= 1'b0;
        end else if (accept) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_addr  <= {mem_addr[31:2], 2'b00};
            bus_be    <= be_c;
            bus_wdata <= wdata_c;
            is_load   <= !mem_we;
            kill      <= 1'b0;
        end else if (state == BUSY) begin
            // A flush never abandons the transaction, it only marks the
            // load result as dead.
            if (flush)   kill    <= 1'b1;
            if (bus_ack) bus_req <= 1'b0;
        end
    end

    // WB side: only loads touch these; a flushed load still updates
    // wb_rdata but does not pulse wb_valid (flush in the ack cycle counts).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid <= 1'b0;
            wb_rdata <= 32'h0;
            wb_a     <= 2'b00;
            wb_op    <= 3'b000;
        end else begin
            wb_valid <= (state == BUSY) && bus_ack && is_load && !(kill || flush);
            if (accept && !mem_we) begin
                wb_a  <= mem_addr[1:0];
                wb_op <= mem_ld_op;
            end
            if ((state == BUSY) && bus_ack && is_load)
                wb_rdata <= bus_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit. A transaction-level model (expected
// output registers updated per access from enable/replication arithmetic)
// is compared against every DUT output on each falling edge; a few literal
// expectations from hand calculation pin the model.
`timescale 1ns/1ps
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_valid, mem_we, flush, bus_ack;
    logic [1:0]  mem_size;
    logic [2:0]  mem_ld_op;
    logic [31:0] mem_addr, mem_wdata, bus_rdata;
    logic        stall, bus_req, bus_we, wb_valid, exc_adel, exc_ades;
    logic [31:0] bus_addr, bus_wdata, wb_rdata;
    logic [3:0]  bus_be;
    logic [1:0]  wb_a;
    logic [2:0]  wb_op;

    dmem_access_unit dut (
        .clk(clk), .reset_n(reset_n),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_size(mem_size),
        .mem_ld_op(mem_ld_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .flush(flush), .stall(stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .wb_valid(wb_valid), .wb_rdata(wb_rdata), .wb_a(wb_a), .wb_op(wb_op),
        .exc_adel(exc_adel), .exc_ades(exc_ades)
    );

    always #5 clk = ~clk;

    // Model of expected outputs for the current cycle.
    logic        e_stall, e_req, e_we, e_wbv, e_adel, e_ades;
    logic [31:0] e_addr, e_wd, e_rd;
    logic [3:0]  e_be;
    logic [1:0]  e_a;
    logic [2:0]  e_op;

    int n_pass = 0;
    int n_tot  = 0;
    int stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        chk("stall",     {31'h0, stall},    {31'h0, e_stall});
        chk("bus_req",   {31'h0, bus_req},  {31'h0, e_req});
        chk("bus_we",    {31'h0, bus_we},   {31'h0, e_we});
        chk("bus_addr",  bus_addr,          e_addr);
        chk("bus_be",    {28'h0, bus_be},   {28'h0, e_be});
        chk("bus_wdata", bus_wdata,         e_wd);
        chk("wb_valid",  {31'h0, wb_valid}, {31'h0, e_wbv});
        chk("wb_rdata",  wb_rdata,          e_rd);
        chk("wb_a",      {30'h0, wb_a},     {30'h0, e_a});
        chk("wb_op",     {29'h0, wb_op},    {29'h0, e_op});
        chk("exc_adel",  {31'h0, exc_adel}, {31'h0, e_adel});
        chk("exc_ades",  {31'h0, exc_ades}, {31'h0, e_ades});
        if (stall === 1'b1) stall_cnt++;
    end

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int off;
        off = (sz == 2'b01) ? 2 * int'(a[1]) : (sz == 2'b10) ? int'(a[1:0]) : 0;
        return 4'(((1 << nbytes(sz)) - 1) << off);
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        int nb;
        nb = nbytes(sz);
        r = 32'h0;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = wd[(i % nb)*8 +: 8];
        return r;
    endfunction

    function automatic logic m_misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
        return ((sz == 2'b01) && a[0]) || ((sz == 2'b00 || sz == 2'b11) && (a[1:0] != 2'b00));
`else
        return 1'b0;
`endif
    endfunction

    // One clock: let the compare process sample, then move past the edge.
    task automatic step();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        e_stall = 0; e_req = 0; e_we = 0; e_wbv = 0; e_adel = 0; e_ades = 0;
        e_addr = 0; e_wd = 0; e_rd = 0; e_be = 0; e_a = 0; e_op = 0;
    endtask

    // Full access: request cycle, nwait wait cycles, ack cycle. flush_at
    // selects the BUSY cycle index (0..nwait) to pulse flush, -1 for none.
    // Returns in the cycle after the ack cycle.
    task automatic access(input logic we, input logic [1:0] sz, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int nwait, input logic [31:0] rd, input int flush_at);
        logic killed;
        killed = 1'b0;
        mem_valid = 1; mem_we = we; mem_size = sz; mem_ld_op = op;
        mem_addr = addr; mem_wdata = wd; flush = 0; bus_ack = 0;
        if (m_misaligned(sz, addr)) begin
            e_stall = 0; e_adel = !we; e_ades = we;
            step();
            mem_valid = 0; e_adel = 0; e_ades = 0; e_wbv = 0;
            return;
        end
        e_stall = 1;
        step();
        e_wbv = 0; e_req = 1; e_we = we;
        e_addr = {addr[31:2], 2'b00}; e_be = m_be(sz, addr); e_wd = m_wd(sz, wd);
        if (!we) begin e_a = addr[1:0]; e_op = op; end
        for (int k = 0; k <= nwait; k++) begin
            bus_ack   = (k == nwait);
            bus_rdata = (k == nwait) ? rd : (32'hBAD0_0000 + 32'(k));
            flush     = (k == flush_at);
            if (k == flush_at) killed = 1'b1;
            e_stall   = (k != nwait);
            step();
        end
        bus_ack = 0; flush = 0; mem_valid = 0;
        e_req = 0; e_stall = 0;
        e_wbv = !we && !killed;
        if (!we) e_rd = rd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            mem_valid = 0; flush = 0; bus_ack = 0;
            step();
            e_wbv = 0;
        end
    endtask

    initial begin
        reset_n = 0; mem_valid = 0; mem_we = 0; mem_size = 0; mem_ld_op = 0;
        mem_addr = 0; mem_wdata = 0; flush = 0; bus_ack = 0; bus_rdata = 0;
        model_reset();
        @(posedge clk); #1;
        @(negedge clk); @(posedge clk); #1;
        reset_n = 1;
        idle(1);

        // sw 0x10, zero-wait slave
        stall_cnt = 0;
        access(1, 2'b00, 3'b000, 32'h10, 32'hDEADBEEF, 0, 32'h0, -1);
        chk("sw_stall_cycles", 32'(stall_cnt), 32'd1);
        chk("sw_be", {28'h0, bus_be}, 32'hF);
        chk("sw_wdata", bus_wdata, 32'hDEADBEEF);
        chk("sw_no_wbv", {31'h0, wb_valid}, 32'h0);
        idle(1);

        // sb 0x13
        access(1, 2'b10, 3'b000, 32'h13, 32'h000000A5, 1, 32'h0, -1);
        chk("sb_addr", bus_addr, 32'h10);
        chk("sb_be", {28'h0, bus_be}, 32'h8);
        chk("sb_wdata", bus_wdata, 32'hA5A5A5A5);
        idle(1);

        // lh 0x22, three wait cycles
        stall_cnt = 0;
        access(0, 2'b01, 3'b100, 32'h22, 32'h0, 3, 32'h80011234, -1);
        chk("lh_stall_cycles", 32'(stall_cnt), 32'd4);
        chk("lh_be", {28'h0, bus_be}, 32'hC);
        chk("lh_wbv", {31'h0, wb_valid}, 32'h1);
        chk("lh_rdata", wb_rdata, 32'h80011234);
        chk("lh_a", {30'h0, wb_a}, 32'h2);
        chk("lh_op", {29'h0, wb_op}, 32'h4);

        // store directly behind a load (wb_valid overlaps the request cycle)
        access(1, 2'b01, 3'b000, 32'h16, 32'h1234ABCD, 0, 32'h0, -1);
        chk("sh_wdata", bus_wdata, 32'hABCDABCD);
        chk("sh_rdata_held", wb_rdata, 32'h80011234);

        // flushed lw, then lbu 0x41 back-to-back
        access(0, 2'b00, 3'b000, 32'h40, 32'h0, 2, 32'h11223344, 1);
        chk("flush_no_wbv", {31'h0, wb_valid}, 32'h0);
        chk("flush_rdata", wb_rdata, 32'h11223344);
        access(0, 2'b10, 3'b001, 32'h41, 32'h0, 0, 32'h000055AA, -1);
        chk("lbu_be", {28'h0, bus_be}, 32'h2);
        chk("lbu_wbv", {31'h0, wb_valid}, 32'h1);

        // flush on the ack cycle itself still suppresses wb_valid
        access(0, 2'b00, 3'b000, 32'h80, 32'h0, 1, 32'hCAFEF00D, 1);
        // size 11 behaves as word; lb at offset 3
        access(0, 2'b11, 3'b000, 32'h84, 32'h0, 0, 32'h01020304, -1);
        access(0, 2'b10, 3'b010, 32'h87, 32'h0, 2, 32'hFF000000, -1);
        idle(1);

        // flush while idle: no request, no stall
        mem_valid = 1; mem_we = 0; mem_size = 0; mem_addr = 32'h100; flush = 1;
        e_stall = 0;
        step();
        idle(1);

        // misaligned lw 0x06
        access(0, 2'b00, 3'b000, 32'h06, 32'h0, 0, 32'h76543210, -1);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("mis_no_req", {31'h0, bus_req}, 32'h0);
`else
        chk("mis_addr", bus_addr, 32'h04);
        chk("mis_be", {28'h0, bus_be}, 32'hF);
`endif
        idle(1);

        // reset asserted during BUSY
        mem_valid = 1; mem_we = 0; mem_size = 2'b00; mem_ld_op = 3'b000;
        mem_addr = 32'h200; flush = 0; bus_ack = 0;
        e_stall = 1;
        step();
        e_req = 1; e_we = 0; e_addr = 32'h200; e_be = 4'hF; e_wd = m_wd(2'b00, mem_wdata);
        e_a = 2'b00; e_op = 3'b000; e_stall = 1; e_wbv = 0;
        step();
        reset_n = 0;
        model_reset();
        #1;
        chk("rst_req", {31'h0, bus_req}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_rdata", wb_rdata, 32'h0);
        step();
        reset_n = 1; mem_valid = 0;
        idle(2);
        access(0, 2'b01, 3'b011, 32'h300, 32'h0, 1, 32'h0000BEEF, -1);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
